// File: rtl/vga_pixel_fetch.sv
// Maps active 640x480 VGA pixels onto a 2x-upscaled, optionally mirrored 320x240 image ROM.
// Define MIRROR_FRAME_LOCK_EN to apply mirror switch changes only at the start of vertical blanking.
module vga_pixel_fetch #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hmir,
  input  logic              vmir,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        vgaRed,
  output logic [3:0]        vgaGreen,
  output logic [3:0]        vgaBlue,
  output logic              hsync,
  output logic              vsync
);

  logic hmir_m, hmir_s, vmir_m, vmir_s;
  logic hm_q, vm_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hmir_m <= 1'b0;
      hmir_s <= 1'b0;
      vmir_m <= 1'b0;
      vmir_s <= 1'b0;
    end else begin
      hmir_m <= hmir;
      hmir_s <= hmir_m;
      vmir_m <= vmir;
      vmir_s <= vmir_m;
    end
  end

`ifdef MIRROR_FRAME_LOCK_EN
  // First line of vertical blanking: safe point to swap mapping without tearing.
  logic lock_stb;
  assign lock_stb = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACT));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hm_q <= 1'b0;
      vm_q <= 1'b0;
    end else if (lock_stb) begin
      hm_q <= hmir_s;
      vm_q <= vmir_s;
    end
  end
`else
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hm_q <= 1'b0;
      vm_q <= 1'b0;
    end else begin
      hm_q <= hmir_s;
      vm_q <= vmir_s;
    end
  end
`endif

  logic [ADDR_W-1:0] x_p0, y_p0, xm_p0, ym_p0, addr_p0;
  logic              act_p0;

  always_comb begin
    x_p0    = ADDR_W'(h_cnt >> 1);
    y_p0    = ADDR_W'(v_cnt >> 1);
    xm_p0   = hm_q ? (ADDR_W'(IMG_W - 1) - x_p0) : x_p0;
    ym_p0   = vm_q ? (ADDR_W'(IMG_H - 1) - y_p0) : y_p0;
    addr_p0 = ym_p0 * ADDR_W'(IMG_W) + xm_p0;
    act_p0  = valid && (h_cnt < 10'(H_ACT)) && (v_cnt < 10'(V_ACT));
  end

  // Stage 1: address register; ROM reads it during the following cycle.
  logic vld_p1, vld_p2;
  logic hs_p1, hs_p2, vs_p1, vs_p2;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      if (act_p0)
        rom_addr <= addr_p0;
      vld_p1 <= act_p0;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  // Stage 2: synchronous ROM access; only control travels here.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // Stage 3: colour register, forced to black outside the active region.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vgaRed   <= 4'd0;
      vgaGreen <= 4'd0;
      vgaBlue  <= 4'd0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      if (vld_p2) begin
        vgaRed   <= rom_data[11:8];
        vgaGreen <= rom_data[7:4];
        vgaBlue  <= rom_data[3:0];
      end else begin
        vgaRed   <= 4'd0;
        vgaGreen <= 4'd0;
        vgaBlue  <= 4'd0;
      end
      hsync <= hs_p2;
      vsync <= vs_p2;
    end
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Sits directly downstream of vga_controller on the 25 MHz pixel clock. Consumes h_cnt/v_cnt/valid/hsync/vsync and maps each active 640x480 screen pixel to an address in a 320x240, 12-bit-per-pixel image ROM, with 2x upscaling and horizontal/vertical mirroring. Drives the ROM address, registers the returned pixel onto vgaRed/vgaGreen/vgaBlue, and delays the syncs so colour and sync stay aligned at the connector.

Parameters:
H_ACT, 640, active pixels per line.
V_ACT, 480, active lines per frame.
IMG_W, 320, image width in pixels (H_ACT >> 1).
IMG_H, 240, image height in lines (V_ACT >> 1).
ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
pclk  in  1  pixel clock (25 MHz)
reset  in  1  asynchronous reset, active-high
h_cnt  in  10  horizontal counter from vga_controller
v_cnt  in  10  vertical counter from vga_controller
valid  in  1  high while (h_cnt, v_cnt) is in the active region
hsync_in  in  1  hsync from vga_controller (active-low)
vsync_in  in  1  vsync from vga_controller (active-low)
hmir  in  1  horizontal-mirror switch, asynchronous level
vmir  in  1  vertical-mirror switch, asynchronous level
rom_addr  out  ADDR_W  image ROM address, registered
rom_data  in  12  ROM read data {R[11:8],G[7:4],B[3:0]}, synchronous ROM, 1-cycle read latency
vgaRed  out  4  red output, registered
vgaGreen  out  4  green output, registered
vgaBlue  out  4  blue output, registered
hsync  out  1  delayed hsync_in
vsync  out  1  delayed vsync_in

Behaviour:
- Clock and reset: one clock, pclk. reset is asynchronous and active-high. All flops clear on reset assertion, independent of pclk.
- Reset values: rom_addr=0; vgaRed/vgaGreen/vgaBlue=0; hsync=1; vsync=1; valid delay chain=0; sync delay chains=1; mirror synchronizers=0; applied mirror state hm_q=0, vm_q=0.
- Mirror inputs: each passes through a 2-flop synchronizer (hmir_s, vmir_s).
- Mirror latch: hm_q/vm_q load hmir_s/vmir_s only on the frame-lock strobe, a single cycle where h_cnt==0 and v_cnt==V_ACT (first vertical-blanking line). A new mirror setting therefore takes effect from the next frame's first active pixel. No tearing.
- Address (stage 1, registered at end of cycle N):
  - x = h_cnt>>1, y = v_cnt>>1.
  - xm = hm_q ? IMG_W-1-x : x; ym = vm_q ? IMG_H-1-y : y.
  - rom_addr = ym*IMG_W + xm, computed at ADDR_W bits with no overflow.
  - When valid==0, rom_addr holds its previous value.
- Stage 2: ROM returns rom_data in cycle N+2.
- Stage 3, output register: visible in cycle N+3.
  - If valid delayed by 2 is 1, {vgaRed,vgaGreen,vgaBlue} = rom_data.
  - Otherwise the colour outputs are 0 (blanking is mandatory).
- Sync alignment: hsync/vsync = hsync_in/vsync_in delayed by exactly 3 pclk cycles. Valid uses a 2-deep delay into stage 3, so colour and sync edges line up.
- Total latency from counters to colour: 3 cycles, fixed.
- Boundaries:
  - x=319 unmirrored maps to column 319; mirrored maps to column 0.
  - Last pixel (639,479) unmirrored gives addr 76799.
  - Counters outside the active region are ignored via valid. h_cnt/v_cnt beyond H_ACT/V_ACT never produce an address update.
- Reset mid-frame: outputs return to reset values immediately. After release, the pipeline refills within 3 cycles. hm_q/vm_q stay 0 until the next frame-lock strobe.

Optional Feature:
MIRROR_FRAME_LOCK_EN
- Defined: mirror state is applied only at the frame-lock strobe, as described above.
- Undefined: hm_q/vm_q follow hmir_s/vmir_s every cycle. Mirroring changes mid-frame, 2 cycles after the synchronizer output changes. The strobe logic is removed.

Test Plan:
- Reset release with hmir=vmir=0; drive valid=1, h_cnt=0, v_cnt=0 -> rom_addr=0 next cycle; rom_data=12'hABC returned -> vgaRed=A, vgaGreen=B, vgaBlue=C exactly 3 cycles after the counters were presented.
- Scaling: h_cnt=639, v_cnt=479 -> rom_addr=76799; h_cnt=1, v_cnt=1 -> rom_addr=0; h_cnt=2, v_cnt=2 -> rom_addr=321.
- Mirroring after a frame-lock strobe: hmir=1 only, (0,0) -> 319; vmir=1 only, (0,0) -> 76480; both set, (0,0) -> 76799.
- Frame lock (macro defined): toggle hmir at v_cnt=100 -> addresses unchanged for the rest of the frame; new mapping from (0,0) of the next frame. With the macro undefined -> mapping changes within 4 cycles of the toggle.
- Blanking and sync: valid=0 with rom_data=12'hFFF -> RGB=0; a hsync_in falling edge at cycle T -> hsync falls at T+3; vsync tracked the same way.
- Assert reset mid-line with RGB nonzero -> RGB=0 and hsync=vsync=1 asynchronously, before the next pclk edge; hm_q/vm_q=0 after release.
